// File: rtl/cordic_arb_pkg.sv
// Shared constants for the CORDIC round-robin arbiter: FSM encoding,
// default sizing and the operation-select encoding understood by the engine.
package cordic_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_W       = 32;

  localparam logic OP_COS = 1'b0;
  localparam logic OP_SIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: finds the first set request bit searching
// upward from the slot after the last grant, wrapping at NUM_REQ (not at a
// power of two), so the winner index never exceeds NUM_REQ-1.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic               o_any_req,
  output logic [IDX_W-1:0]   o_winner
);

  logic [IDX_W:0] w_sum;
  logic [IDX_W:0] w_pos;
  logic           w_hit;
  logic           w_found;

  // Walk the candidates in rotation order and keep the first hit.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_pos    = '0;
    w_hit    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum    = {1'b0, i_last_grant} + (IDX_W+1)'(i);
      w_pos    = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? (w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum;
      w_hit    = ~w_found & i_req[w_pos[IDX_W-1:0]];
      o_winner = w_hit ? w_pos[IDX_W-1:0] : o_winner;
      w_found  = w_found | w_hit;
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter sharing one sine/cosine CORDIC engine between
// NUM_REQ requesters. The winner's angle/operation are latched and held
// stable for the whole transaction; the engine result is returned over a
// per-requester valid/ack handshake. Every output is a register.
module cordic_rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int W       = DEF_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ*W-1:0] req_angle,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]   rsp_ack,
  output logic                 cordic_beg,
  output logic                 cordic_operation,
  output logic [W-1:0]         cordic_angle,
  input  logic                 cordic_ready,
  input  logic [W-1:0]         cordic_result,
  output logic                 cordic_ack,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
);

  arb_state_e         r_state;
  arb_state_e         w_nxt_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_nxt_last_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   w_nxt_grant_idx;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any_req;
  logic               r_op;
  logic               w_nxt_op;
  logic [W-1:0]       r_angle;
  logic [W-1:0]       w_nxt_angle;
  logic [W-1:0]       r_rsp_data;
  logic [W-1:0]       w_nxt_rsp_data;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] w_nxt_req_ready;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [NUM_REQ-1:0] w_nxt_rsp_valid;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               r_beg;
  logic               w_nxt_beg;
  logic               r_ack;
  logic               w_nxt_ack;
  logic               r_busy;
  logic [W-1:0]       w_angle_arr [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_any_req    (w_any_req),
    .o_winner     (w_winner)
  );

  // Unpack the flat angle bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_angle_arr[i] = req_angle[i*W +: W];
    end
  end

  // One-hot decode of the new winner and of the latched grant.
  always_comb begin
    w_win_oh               = '0;
    w_grant_oh             = '0;
    w_win_oh[w_winner]     = 1'b1;
    w_grant_oh[r_grant_idx] = 1'b1;
  end

  // Next-state and next-output logic; pulses default low, latched data holds.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_last_grant = r_last_grant;
    w_nxt_grant_idx  = r_grant_idx;
    w_nxt_op         = r_op;
    w_nxt_angle      = r_angle;
    w_nxt_rsp_data   = r_rsp_data;
    w_nxt_req_ready  = '0;
    w_nxt_rsp_valid  = '0;
    w_nxt_beg        = 1'b0;
    w_nxt_ack        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_nxt_grant_idx = w_winner;
          w_nxt_op        = req_op[w_winner];
          w_nxt_angle     = w_angle_arr[w_winner];
          w_nxt_req_ready = w_win_oh;
          w_nxt_beg       = 1'b1;
          w_nxt_state     = ST_LAUNCH;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_nxt_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (cordic_ready) begin
          w_nxt_rsp_data  = cordic_result;
          w_nxt_ack       = 1'b1;
          w_nxt_rsp_valid = w_grant_oh;
          w_nxt_state     = ST_RESP;
        end else begin
          w_nxt_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ack[r_grant_idx]) begin
          w_nxt_last_grant = r_grant_idx;
          w_nxt_state      = ST_IDLE;
        end else begin
          w_nxt_rsp_valid = w_grant_oh;
          w_nxt_state     = ST_RESP;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset puts requester 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ-1);
      r_grant_idx  <= '0;
      r_op         <= OP_COS;
      r_angle      <= '0;
      r_rsp_data   <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_beg        <= 1'b0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_last_grant <= w_nxt_last_grant;
      r_grant_idx  <= w_nxt_grant_idx;
      r_op         <= w_nxt_op;
      r_angle      <= w_nxt_angle;
      r_rsp_data   <= w_nxt_rsp_data;
      r_req_ready  <= w_nxt_req_ready;
      r_rsp_valid  <= w_nxt_rsp_valid;
      r_beg        <= w_nxt_beg;
      r_ack        <= w_nxt_ack;
      r_busy       <= (w_nxt_state != ST_IDLE);
    end
  end

  assign req_ready        = r_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign cordic_beg       = r_beg;
  assign cordic_operation = r_op;
  assign cordic_angle     = r_angle;
  assign cordic_ack       = r_ack;
  assign busy             = r_busy;
  assign grant_idx        = r_grant_idx;

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a behavioural CORDIC engine,
// an auto-acking requester model and a scoreboard of expected transactions.
module tb_cordic_rr_arbiter;
  import cordic_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_angle;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_ack;
  logic           cordic_beg;
  logic           cordic_operation;
  logic [W-1:0]   cordic_angle;
  logic           cordic_ready;
  logic [W-1:0]   cordic_result;
  logic           cordic_ack;
  logic           busy;
  logic [IW-1:0]  grant_idx;

  typedef struct {
    logic [IW-1:0] idx;
    logic          op;
    logic [W-1:0]  angle;
    logic [W-1:0]  res;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_beg = 0;
  int           rdy_cyc = 0;
  int           eng_lat = 4;
  int           eng_cnt = 0;
  int           stall = 0;
  bit           spurious = 0;
  bit           noise = 0;
  bit           eng_busy = 0;
  bit           eng_rdy = 0;
  logic [W-1:0] eng_res = '0;
  bit           mon_active = 0;
  bit           mon_seen = 0;
  int           mon_acks = 0;
  logic [W-1:0] tb_angle [N];
  logic         tb_op [N];

  cordic_rr_arbiter #(.NUM_REQ(N), .W(W), .IDX_W(IW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_angle        (req_angle),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_ack          (rsp_ack),
    .cordic_beg       (cordic_beg),
    .cordic_operation (cordic_operation),
    .cordic_angle     (cordic_angle),
    .cordic_ready     (cordic_ready),
    .cordic_result    (cordic_result),
    .cordic_ack       (cordic_ack),
    .busy             (busy),
    .grant_idx        (grant_idx)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Engine result model: the one known sine point, otherwise a reversible scramble.
  function automatic logic [W-1:0] engine_fn(input logic [W-1:0] a, input logic op);
    if (a == 32'h3F49_0FDB && op == OP_SIN) return 32'h3F35_04F3;
    return {a[15:0], a[31:16]} ^ ((op == OP_SIN) ? 32'hFFFF_0000 : 32'h0000_FFFF);
  endfunction

  function automatic logic [N-1:0] oh(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [W-1:0] angle);
    tb_op[i]              = op;
    tb_angle[i]           = angle;
    req_op[i]             = op;
    req_angle[i*W +: W]   = angle;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.idx   = IW'(i);
    e.op    = tb_op[i];
    e.angle = tb_angle[i];
    e.res   = engine_fn(tb_angle[i], tb_op[i]);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(4'b0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(4'b0));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(32'h0));
    check({tag, "_beg"}, 64'(cordic_beg), 64'(1'b0));
    check({tag, "_op"}, 64'(cordic_operation), 64'(1'b0));
    check({tag, "_angle"}, 64'(cordic_angle), 64'(32'h0));
    check({tag, "_ack"}, 64'(cordic_ack), 64'(1'b0));
    check({tag, "_busy"}, 64'(busy), 64'(1'b0));
    check({tag, "_grant"}, 64'(grant_idx), 64'(2'b0));
  endtask

  task automatic wait_begs(input int target, input int budget, input string tag);
    int k = 0;
    while (n_beg < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(n_beg >= target), 64'(1'b1));
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // CORDIC engine model: result after eng_lat cycles, held until acked.
  initial begin
    cordic_ready  = 1'b0;
    cordic_result = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        eng_busy = 1'b0;
        eng_rdy  = 1'b0;
      end else begin
        if (cordic_ack) eng_rdy = 1'b0;
        if (cordic_beg) begin
          eng_busy = 1'b1;
          eng_cnt  = eng_lat;
          eng_res  = engine_fn(cordic_angle, cordic_operation);
        end else if (eng_busy) begin
          if (eng_cnt <= 1) begin
            eng_busy = 1'b0;
            eng_rdy  = 1'b1;
            rdy_cyc  = cyc;
          end else begin
            eng_cnt--;
          end
        end
      end
      cordic_ready  = eng_rdy | spurious;
      cordic_result = eng_rdy ? eng_res : (spurious ? 32'hDEAD_BEEF : 32'h0);
    end
  end

  // Requester ack model: optional stall with acks on the wrong bits, optional noise.
  initial begin
    rsp_ack = '0;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != '0) begin
        if (stall > 0) begin
          stall--;
          rsp_ack = ~rsp_valid;
        end else begin
          rsp_ack = rsp_valid;
        end
      end else begin
        rsp_ack = (noise && !reset) ? 4'hF : 4'h0;
      end
    end
  end

  // Scoreboard monitor: grant, stability, response and handshake checks.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
        mon_seen   = 1'b0;
        mon_acks   = 0;
      end else begin
        if (mon_active) begin
          check("beg_while_busy", 64'(cordic_beg), 64'(1'b0));
        end else if (cordic_beg) begin
          n_beg++;
          if (exp_q.size() == 0) begin
            check("unexpected_beg", 64'(cordic_beg), 64'(1'b0));
          end else begin
            check("grant_idx", 64'(grant_idx), 64'(exp_q[0].idx));
            check("req_ready", 64'(req_ready), 64'(oh(exp_q[0].idx)));
            mon_active = 1'b1;
            mon_seen   = 1'b0;
            mon_acks   = 0;
          end
        end else begin
          check("idle_quiet", 64'({rsp_valid, cordic_ack, req_ready}), 64'(9'b0));
        end
        if (mon_active) begin
          if (cordic_ack) mon_acks++;
          if (!mon_seen || rsp_valid != '0) begin
            check("op_stable", 64'(cordic_operation), 64'(exp_q[0].op));
            check("angle_stable", 64'(cordic_angle), 64'(exp_q[0].angle));
            check("busy_high", 64'(busy), 64'(1'b1));
          end
          if (!mon_seen && rsp_valid != '0) begin
            mon_seen = 1'b1;
            check("rsp_data", 64'(rsp_data), 64'(exp_q[0].res));
            check("rsp_valid", 64'(rsp_valid), 64'(oh(exp_q[0].idx)));
            check("ack_with_valid", 64'(cordic_ack), 64'(1'b1));
            check("rsp_latency", 64'(cyc - rdy_cyc), 64'(1));
          end else if (mon_seen && rsp_valid != '0) begin
            check("rsp_hold_data", 64'(rsp_data), 64'(exp_q[0].res));
            check("rsp_hold_valid", 64'(rsp_valid), 64'(oh(exp_q[0].idx)));
            check("ack_single", 64'(cordic_ack), 64'(1'b0));
          end else if (mon_seen) begin
            check("ack_count", 64'(mon_acks), 64'(1));
            check("idle_after_ack", 64'(busy), 64'(1'b0));
            void'(exp_q.pop_front());
            mon_active = 1'b0;
            mon_seen   = 1'b0;
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int base;
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_angle = '0;
    for (int i = 0; i < N; i++) set_req(i, OP_COS, 32'h0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // All four request together and hold: grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h1111_1111 * (i + 1) + 32'h0000_0101);
    eng_lat = 3;
    push(0); push(1); push(2); push(3); push(0);
    base = n_beg;
    req_valid = 4'b1111;
    wait_begs(base + 5, 400, "wait_all4");
    req_valid = 4'b0000;
    wait_drain(200, "drain_all4");

    // Single request with the known sine point and a long engine latency.
    set_req(2, OP_SIN, 32'h3F49_0FDB);
    push(2);
    eng_lat = 40;
    req_valid = 4'b0100;
    @(negedge clk);
    check("beg_latency", 64'(cordic_beg), 64'(1'b1));
    check("ready_latency", 64'(req_ready), 64'(4'b0100));
    req_valid = 4'b0000;
    wait_drain(200, "drain_single");

    // Stalled response with acks on non-granted bits and acks outside RESP.
    set_req(1, OP_COS, 32'h4049_0FDB);
    push(1);
    eng_lat = 6;
    stall   = 20;
    noise   = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("stall_beg", 64'(cordic_beg), 64'(1'b1));
    req_valid = 4'b0000;
    for (int k = 0; k < 50 && rsp_valid == '0; k++) @(negedge clk);
    check("stall_rsp_seen", 64'(rsp_valid), 64'(4'b0010));
    repeat (10) begin
      @(negedge clk);
      check("stall_busy", 64'(busy), 64'(1'b1));
      check("stall_no_beg", 64'(cordic_beg), 64'(1'b0));
      check("stall_valid", 64'(rsp_valid), 64'(4'b0010));
    end
    wait_drain(100, "drain_stall");
    noise = 1'b0;

    // Spurious engine ready while idle.
    spurious = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("spur_ack", 64'(cordic_ack), 64'(1'b0));
      check("spur_valid", 64'(rsp_valid), 64'(4'b0));
      check("spur_busy", 64'(busy), 64'(1'b0));
    end
    spurious = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in WAIT, then requesters 0 and 3 pending: 0 wins first.
    set_req(3, OP_SIN, 32'hBF00_1234);
    set_req(0, OP_COS, 32'h3E80_0000);
    push(3);
    eng_lat = 30;
    base = n_beg;
    req_valid = 4'b1000;
    wait_begs(base + 1, 20, "wait_pre_reset");
    req_valid = 4'b0000;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    exp_q.delete();
    req_valid = 4'b1001;
    repeat (2) @(negedge clk);
    push(0); push(3);
    eng_lat = 4;
    base = n_beg;
    reset = 1'b0;
    wait_begs(base + 2, 100, "wait_post_reset");
    req_valid = 4'b0000;
    wait_drain(100, "drain_post_reset");

    // Fairness: 0 requests continuously, 1 requests once.
    set_req(0, OP_SIN, 32'h3DCC_CCCD);
    set_req(1, OP_COS, 32'h3F80_0000);
    push(0); push(1); push(0);
    base = n_beg;
    req_valid = 4'b0001;
    wait_begs(base + 1, 20, "wait_fair0");
    req_valid[1] = 1'b1;
    wait_begs(base + 2, 50, "wait_fair1");
    req_valid[1] = 1'b0;
    wait_begs(base + 3, 50, "wait_fair2");
    req_valid = 4'b0000;
    wait_drain(100, "drain_fair");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
